// File: rtl/nmu_req_packetizer.sv
// NoC master unit request packetizer: accepts one AXI command, drives the address-map
// lookup, and queues one or two header flits in a small FIFO for the injection port.
module nmu_req_packetizer #(
  parameter int                     AXI_ADDR_WIDTH = 32,
  parameter int                     AXI_ID_WIDTH   = 4,
  parameter int                     ID_WIDTH       = 4,
  parameter logic [ID_WIDTH-1:0]    SRC_ID         = '0,
  parameter int                     HDR_FIFO_DEPTH = 4,
  parameter int                     LOOKUP_TIMEOUT = 16
) (
  input  logic                                                     axi_clk,
  input  logic                                                     axi_rst_n,
  input  logic                                                     cmd_valid,
  output logic                                                     cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]                                cmd_addr,
  input  logic [7:0]                                               cmd_len,
  input  logic [AXI_ID_WIDTH-1:0]                                  cmd_id,
  input  logic                                                     cmd_write,
  output logic                                                     lookup_en,
  output logic [AXI_ADDR_WIDTH-1:0]                                lookup_addr,
  output logic [7:0]                                               lookup_len,
  output logic                                                     next_req,
  input  logic                                                     dest_en,
  input  logic [AXI_ADDR_WIDTH-1:0]                                dest_addr,
  input  logic [7:0]                                               dest_len,
  input  logic [ID_WIDTH-1:0]                                      dest_id,
  input  logic                                                     lookup_done,
  output logic                                                     hdr_valid,
  input  logic                                                     hdr_ready,
  output logic [2+2*ID_WIDTH+AXI_ID_WIDTH+8+AXI_ADDR_WIDTH-1:0]    hdr_data,
  output logic                                                     lookup_err
);
  localparam int HDR_WIDTH = 2 + 2*ID_WIDTH + AXI_ID_WIDTH + 8 + AXI_ADDR_WIDTH;
  localparam int PTR_W     = $clog2(HDR_FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int TMO_W     = $clog2(LOOKUP_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, SPLIT} state_t;

  state_t                  state, state_nxt;
  logic                    active;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic                    write_q;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [HDR_WIDTH-1:0]    mem [HDR_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    accept, push, pop, push_last, timeout;

  // active keeps cmd_ready low through reset and lets it rise one cycle after release
  assign cmd_ready = active && (state == IDLE) && (count <= CNT_W'(HDR_FIFO_DEPTH - 2));
  assign accept    = cmd_valid && cmd_ready;
  assign hdr_valid = (count != '0);
  assign pop       = hdr_valid && hdr_ready;
  assign hdr_data  = mem[rd_ptr];
  assign next_req  = (state == SPLIT);
  assign timeout   = (tmo_cnt == TMO_W'(LOOKUP_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_last  = 1'b0;
    lookup_err = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOOKUP;
      LOOKUP: begin
        if (dest_en) begin
          push      = 1'b1;
          push_last = lookup_done;
          state_nxt = lookup_done ? IDLE : SPLIT;
        end else if (timeout) begin
          lookup_err = 1'b1;
          state_nxt  = IDLE;
        end
      end
      SPLIT: begin
        if (dest_en) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          lookup_err = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      state       <= IDLE;
      active      <= 1'b0;
      lookup_en   <= 1'b0;
      lookup_addr <= '0;
      lookup_len  <= '0;
      id_q        <= '0;
      write_q     <= 1'b0;
      tmo_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state     <= state_nxt;
      active    <= 1'b1;
      lookup_en <= accept;
      // watchdog spans LOOKUP and SPLIT together; only a new command clears it
      if (accept) begin
        lookup_addr <= cmd_addr;
        lookup_len  <= cmd_len;
        id_q        <= cmd_id;
        write_q     <= cmd_write;
        tmo_cnt     <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr] <= {push_last, write_q, dest_id, SRC_ID, id_q, dest_len, dest_addr};
  end
endmodule

// File: tb/tb_nmu_req_packetizer.sv
// Directed bench for nmu_req_packetizer: the bench plays the address map, and a header
// scoreboard checks every flit popped from the FIFO against the expected order.
module tb_nmu_req_packetizer;
  localparam int AW = 32, IW = 4, NW = 4, DEPTH = 4, TMO = 16;
  localparam logic [NW-1:0] SRC = 4'b0000;
  localparam int HW = 2 + 2*NW + IW + 8 + AW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, lookup_addr, dest_addr = '0;
  logic [7:0]    cmd_len = '0, lookup_len, dest_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [NW-1:0] dest_id = '0;
  logic          lookup_en, next_req, dest_en = 1'b0, lookup_done = 1'b0;
  logic          hdr_valid, hdr_ready = 1'b0, lookup_err;
  logic [HW-1:0] hdr_data;

  int vectors = 0, miscompares = 0;
  logic [HW-1:0] expq[$];

  typedef struct packed {
    logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id; logic wr; logic split;
    logic [NW-1:0] d0; logic [7:0] l0; logic [AW-1:0] a0;
    logic [NW-1:0] d1; logic [7:0] l1; logic [AW-1:0] a1; logic done1;
  } vec_t;
  vec_t tbl[5];

  nmu_req_packetizer #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .ID_WIDTH(NW), .SRC_ID(SRC),
                       .HDR_FIFO_DEPTH(DEPTH), .LOOKUP_TIMEOUT(TMO)) dut (
    .axi_clk(clk), .axi_rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_write(cmd_write),
    .lookup_en(lookup_en), .lookup_addr(lookup_addr), .lookup_len(lookup_len),
    .next_req(next_req), .dest_en(dest_en), .dest_addr(dest_addr), .dest_len(dest_len),
    .dest_id(dest_id), .lookup_done(lookup_done), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .hdr_data(hdr_data), .lookup_err(lookup_err));

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] hdr(input logic last, input logic wr, input logic [NW-1:0] d,
                                        input logic [IW-1:0] id, input logic [7:0] l,
                                        input logic [AW-1:0] a);
    return {last, wr, d, SRC, id, l, a};
  endfunction

  // scoreboard: sample just before each rising edge, when a pop is about to happen
  initial forever begin
    @(negedge clk); #4;
    if (rst_n && hdr_valid && hdr_ready) begin
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL hdr_unexpected: got %h expected no header", hdr_data);
      end else begin
        chkw("hdr_data", hdr_data, expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id,
                          input logic wr);
    int n = 0;
    cmd_addr = a; cmd_len = l; cmd_id = id; cmd_write = wr; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("cmd_ready_after_accept", cmd_ready, 1'b0);
    chk1("lookup_en_pulse", lookup_en, 1'b1);
    chkw("lookup_addr", HW'(lookup_addr), HW'(a));
    chkw("lookup_len", HW'(lookup_len), HW'(l));
    chk1("next_req_lookup", next_req, 1'b0);
  endtask

  task automatic respond(input logic [NW-1:0] d, input logic [7:0] l, input logic [AW-1:0] a,
                         input logic done, input logic last, input logic wr,
                         input logic [IW-1:0] id);
    dest_en = 1'b1; dest_id = d; dest_len = l; dest_addr = a; lookup_done = done;
    expq.push_back(hdr(last, wr, d, id, l, a));
    @(negedge clk);
    dest_en = 1'b0; lookup_done = 1'b0;
  endtask

  task automatic issue(input int i);
    vec_t t = tbl[i];
    send_cmd(t.addr, t.len, t.id, t.wr);
    respond(t.d0, t.l0, t.a0, !t.split, !t.split, t.wr, t.id);
    chk1("lookup_en_single", lookup_en, 1'b0);
    chk1("hdr_valid_first", hdr_valid, 1'b1);
    chk1("next_req_first", next_req, t.split);
    if (t.split) begin
      chkw("lookup_addr_hold", HW'(lookup_addr), HW'(t.addr));
      respond(t.d1, t.l1, t.a1, t.done1, 1'b1, t.wr, t.id);
      chk1("hdr_valid_second", hdr_valid, 1'b1);
      chk1("next_req_second", next_req, 1'b0);
    end
  endtask

  initial begin
    int errs, at;
    logic rdy_after;
    // addr, len, id, wr, split, d0, l0, a0, d1, l1, a1, done1 (map: bit 12 even=PL 3, odd=PS 1)
    tbl[0] = '{32'h100,  8'd15,  4'd2,  1'b1, 1'b0, 4'h3, 8'd15,  32'h100,  4'h0, 8'd0, 32'h0,    1'b0};
    tbl[1] = '{32'hF80,  8'd15,  4'd0,  1'b0, 1'b1, 4'h3, 8'd7,   32'hF80,  4'h1, 8'd7, 32'h1000, 1'b1};
    tbl[2] = '{32'h2000, 8'd3,   4'd5,  1'b0, 1'b0, 4'h3, 8'd3,   32'h2000, 4'h0, 8'd0, 32'h0,    1'b0};
    tbl[3] = '{32'h1FF0, 8'd1,   4'd7,  1'b1, 1'b1, 4'h1, 8'd0,   32'h1FF0, 4'h3, 8'd0, 32'h2000, 1'b0};
    tbl[4] = '{32'h3000, 8'd255, 4'd15, 1'b1, 1'b0, 4'h1, 8'd255, 32'h3000, 4'h0, 8'd0, 32'h0,    1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_hdr_valid", hdr_valid, 1'b0);
    chk1("rst_lookup_en", lookup_en, 1'b0);
    chk1("rst_next_req", next_req, 1'b0);
    chk1("rst_lookup_err", lookup_err, 1'b0);
    chkw("rst_lookup_addr", HW'(lookup_addr), '0);
    chkw("rst_lookup_len", HW'(lookup_len), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("cmd_ready_after_release", cmd_ready, 1'b1);

    // stray dest_en in IDLE must not push
    hdr_ready = 1'b1;
    dest_en = 1'b1; dest_id = 4'h5; dest_len = 8'd9; dest_addr = 32'hDEAD0; lookup_done = 1'b1;
    @(negedge clk);
    dest_en = 1'b0; lookup_done = 1'b0;
    chk1("stray_hdr_valid", hdr_valid, 1'b0);
    @(negedge clk);
    chk1("stray_hdr_valid_later", hdr_valid, 1'b0);

    for (int i = 0; i < 5; i++) begin
      issue(i);
      chk1("cmd_ready_back", cmd_ready, 1'b1);
      @(negedge clk);
      chk1("drained", hdr_valid, 1'b0);
    end

    // backpressure: two splits fill the 4-deep FIFO
    hdr_ready = 1'b0;
    issue(1);
    chk1("bp_ready_half", cmd_ready, 1'b1);
    issue(3);
    @(negedge clk);
    chk1("bp_full_valid", hdr_valid, 1'b1);
    chk1("bp_full_ready", cmd_ready, 1'b0);
    hdr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk1("bp_drain_valid", hdr_valid, 1'b1);
      chk1("bp_drain_ready", cmd_ready, (4 - k) <= 2);
      @(negedge clk);
    end
    chk1("bp_empty", hdr_valid, 1'b0);
    chk1("bp_queue_empty", expq.size() == 0, 1'b1);

    // timeout from LOOKUP
    errs = 0; at = -1; rdy_after = 1'b0;
    send_cmd(32'h4000, 8'd0, 4'd1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (lookup_err) begin errs++; at = k; end
      if (k == 17) rdy_after = cmd_ready;
      @(negedge clk);
    end
    chk1("tmo_err_once", errs == 1, 1'b1);
    chk1("tmo_err_cycle", at == 16, 1'b1);
    chk1("tmo_ready_next", rdy_after, 1'b1);
    chk1("tmo_no_push", hdr_valid, 1'b0);

    // timeout from SPLIT: watchdog keeps counting, queued header survives
    hdr_ready = 1'b0; errs = 0; at = -1;
    send_cmd(tbl[1].addr, tbl[1].len, tbl[1].id, tbl[1].wr);
    respond(tbl[1].d0, tbl[1].l0, tbl[1].a0, 1'b0, 1'b0, tbl[1].wr, tbl[1].id);
    for (int k = 2; k <= 20; k++) begin
      if (lookup_err) begin errs++; at = k; end
      @(negedge clk);
    end
    chk1("tmo_split_once", errs == 1, 1'b1);
    chk1("tmo_split_cycle", at == 16, 1'b1);
    chk1("tmo_split_kept", hdr_valid, 1'b1);
    chk1("tmo_split_next_req", next_req, 1'b0);
    hdr_ready = 1'b1;
    @(negedge clk);
    chk1("tmo_split_drained", hdr_valid, 1'b0);

    // reset while in SPLIT with one header queued
    hdr_ready = 1'b0;
    send_cmd(tbl[3].addr, tbl[3].len, tbl[3].id, tbl[3].wr);
    respond(tbl[3].d0, tbl[3].l0, tbl[3].a0, 1'b0, 1'b0, tbl[3].wr, tbl[3].id);
    chk1("pre_rst_next_req", next_req, 1'b1);
    rst_n = 1'b0;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk1("rst_split_hdr_valid", hdr_valid, 1'b0);
    chk1("rst_split_next_req", next_req, 1'b0);
    @(negedge clk);
    chk1("rst_split_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_split_hdr_still0", hdr_valid, 1'b0);

    chk1("final_queue_empty", expq.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
